// File: rtl/half_adder_checker.sv
// Response checker for a half adder: samples a/b/sum/carry once per vector
// period, scores against a^b / a&b, and reports coverage and a pass verdict.
module half_adder_checker #(
    parameter int PERIOD      = 20,
    parameter int SAMPLE_AT   = 19,
    parameter int NUM_VECTORS = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       coverage,
    output logic [3:0]       first_err,
    output logic             first_err_valid
);
    localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int VEC_W = $clog2(NUM_VECTORS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [PH_W-1:0]    phase, phase_nxt, cur_phase;
    logic [VEC_W-1:0]   vec, vec_nxt, cur_vec;
    logic [ERR_W-1:0]   err_nxt;
    logic [3:0]         cov_nxt, ferr_nxt;
    logic               ferr_v_nxt, pass_nxt;
    logic               launch, active, sample, mismatch, wrap, last;

    // The start cycle itself is phase 0 of vector 0, so it is treated as an
    // active cycle; the registered phase/vec always describe the current cycle.
    always_comb begin
        launch    = start && (state != RUN);
        active    = launch || (state == RUN);
        cur_phase = launch ? '0 : phase;
        cur_vec   = launch ? '0 : vec;
        sample    = active && (cur_phase == PH_W'(SAMPLE_AT));
        mismatch  = (sum != (a ^ b)) || (carry != (a & b));
        wrap      = (cur_phase == PH_W'(PERIOD - 1));
        last      = active && wrap && (cur_vec == VEC_W'(NUM_VECTORS - 1));

        err_nxt    = launch ? '0 : err_count;
        cov_nxt    = launch ? '0 : coverage;
        ferr_nxt   = launch ? '0 : first_err;
        ferr_v_nxt = launch ? 1'b0 : first_err_valid;
        pass_nxt   = launch ? 1'b0 : pass;

        if (sample) begin
            cov_nxt[{a, b}] = 1'b1;
            if (mismatch) begin
                if (err_nxt != '1)
                    err_nxt = err_nxt + 1'b1;
                if (!ferr_v_nxt) begin
                    ferr_nxt   = {a, b, sum, carry};
                    ferr_v_nxt = 1'b1;
                end
            end
        end

        // Verdict folds in the final sample, which may land on this same cycle.
        if (last)
            pass_nxt = (err_nxt == '0) && (cov_nxt == 4'b1111);

        phase_nxt = phase;
        vec_nxt   = vec;
        if (active) begin
            phase_nxt = wrap ? '0 : cur_phase + 1'b1;
            vec_nxt   = wrap ? cur_vec + 1'b1 : cur_vec;
        end

        state_nxt = state;
        if (last)
            state_nxt = DONE;
        else if (launch)
            state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            phase           <= '0;
            vec             <= '0;
            err_count       <= '0;
            coverage        <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state           <= state_nxt;
            phase           <= phase_nxt;
            vec             <= vec_nxt;
            err_count       <= err_nxt;
            coverage        <= cov_nxt;
            first_err       <= ferr_nxt;
            first_err_valid <= ferr_v_nxt;
            pass            <= pass_nxt;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_half_adder_checker.sv
// Bench for half_adder_checker: a modelled half adder with injectable faults
// feeds the checker; per-sample and end-of-run expectations go through a queue.
module tb_half_adder_checker;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, a = 1'b0, b = 1'b0;
    logic fc0 = 1'b0, inv = 1'b0;
    logic sum, carry, busy, done, pass, first_err_valid;
    logic [7:0] err_count;
    logic [3:0] coverage, first_err;

    logic s_start = 1'b0, s_a = 1'b0, s_b = 1'b0;
    logic s_sum, s_carry, s_busy, s_done, s_pass, s_fv;
    logic [1:0] s_err;
    logic [3:0] s_cov, s_ferr;

    always #5 clk = ~clk;

    assign sum     = (a ^ b) ^ inv;
    assign carry   = fc0 ? 1'b0 : (a & b);
    assign s_sum   = ~(s_a ^ s_b);
    assign s_carry = s_a & s_b;

    half_adder_checker #(.PERIOD(20), .SAMPLE_AT(19), .NUM_VECTORS(4), .ERR_W(8)) u0 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sum(sum), .carry(carry),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .coverage(coverage),
        .first_err(first_err), .first_err_valid(first_err_valid));

    half_adder_checker #(.PERIOD(4), .SAMPLE_AT(1), .NUM_VECTORS(6), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b), .sum(s_sum), .carry(s_carry),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err), .coverage(s_cov),
        .first_err(s_ferr), .first_err_valid(s_fv));

    typedef struct {
        logic [7:0] err;
        logic [3:0] cov;
        logic [3:0] ferr;
        logic       fv;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Main instance: 4 vectors of 20 cycles, vector 0 in vecs[7:6].
    task automatic run(input logic [7:0] vecs, input int extra, input int abort);
        exp_t e, p;
        int m_err = 0;
        logic [3:0] m_cov = '0, m_ferr = '0;
        logic m_fv = 1'b0;
        for (int c = 0; c < 80; c++) begin
            logic [1:0] v;
            logic sm, cm;
            v = vecs[7 - 2*(c/20) -: 2];
            a = v[1]; b = v[0];
            start = (c == 0) || (c == extra);
            reset = (c == abort);
            if (c % 20 == 19) begin
                sm = (a ^ b) ^ inv;
                cm = fc0 ? 1'b0 : (a & b);
                m_cov[{a, b}] = 1'b1;
                if (sm != (a ^ b) || cm != (a & b)) begin
                    if (m_err < 255) m_err++;
                    if (!m_fv) begin m_ferr = {a, b, sm, cm}; m_fv = 1'b1; end
                end
                e = '{8'(m_err), m_cov, m_ferr, m_fv};
                q.push_back(e);
            end
            @(negedge clk);
            start = 1'b0; reset = 1'b0;
            if (c == abort) begin
                check("abort_clear", {busy, done, pass, err_count, coverage, first_err, first_err_valid}, 0);
                q.delete();
                return;
            end
            if (c == 0) check("start_clear", {err_count, coverage, first_err_valid, pass}, 0);
            if (q.size() > 0) begin
                p = q.pop_front();
                check("err_count", err_count, p.err);
                check("coverage", coverage, p.cov);
                check("first_err", {first_err_valid, first_err}, {p.fv, p.ferr});
            end
            if (c < 79) check("busy", {busy, done}, 2'b10);
        end
        check("done", {busy, done}, 2'b01);
        check("pass", pass, (m_err == 0) && (m_cov == 4'hF));
        check("final_err", err_count, m_err);
    endtask

    // Saturation instance: 6 vectors of 4 cycles, sum always inverted.
    task automatic run_sat(input logic [11:0] vecs);
        exp_t e, p;
        int m_err = 0;
        logic [3:0] m_cov = '0, m_ferr = '0;
        logic m_fv = 1'b0;
        for (int c = 0; c < 24; c++) begin
            logic [1:0] v;
            v = vecs[11 - 2*(c/4) -: 2];
            s_a = v[1]; s_b = v[0];
            s_start = (c == 0);
            if (c % 4 == 1) begin
                m_cov[{s_a, s_b}] = 1'b1;
                if (m_err < 3) m_err++;
                if (!m_fv) begin m_ferr = {s_a, s_b, ~(s_a ^ s_b), s_a & s_b}; m_fv = 1'b1; end
                e = '{8'(m_err), m_cov, m_ferr, m_fv};
                q.push_back(e);
            end
            @(negedge clk);
            s_start = 1'b0;
            if (q.size() > 0) begin
                p = q.pop_front();
                check("sat_err", s_err, p.err);
                check("sat_first_err", {s_fv, s_ferr}, {p.fv, p.ferr});
            end
        end
        check("sat_done", {s_busy, s_done}, 2'b01);
        check("sat_final_err", s_err, 2'd3);
        check("sat_first_v0", s_ferr, {vecs[11:10], ~(vecs[11] ^ vecs[10]), vecs[11] & vecs[10]});
        check("sat_pass", s_pass, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_state", {busy, done, pass, err_count, coverage, first_err, first_err_valid}, 0);
        check("sat_reset_state", {s_busy, s_done, s_pass, s_err, s_cov, s_ferr, s_fv}, 0);

        run(8'b00_01_10_11, -1, -1);
        check("good_pass", pass, 1'b1);
        check("good_cov", coverage, 4'b1111);

        fc0 = 1'b1;
        run(8'b00_01_10_11, -1, -1);
        fc0 = 1'b0;
        check("carry0_err", err_count, 8'd1);
        check("carry0_first", first_err, 4'b1100);

        run(8'b00_01_01_00, -1, -1);
        check("partial_cov", coverage, 4'b0011);
        check("partial_pass", pass, 1'b0);

        run(8'b11_10_01_00, 10, -1);
        check("ignored_start_pass", pass, 1'b1);

        run(8'b00_01_10_11, -1, 30);
        run(8'b01_11_00_10, -1, -1);
        check("after_reset_pass", pass, 1'b1);

        run_sat(12'b00_01_10_11_01_10);
        check("sat_cov", s_cov, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
